// File: rtl/load_ext_pkg.sv
// Shared encodings and helpers for the load-data aligner/extender.
package load_ext_pkg;

  typedef enum logic [1:0] {
    LD_SZ_BYTE = 2'd0,
    LD_SZ_HALF = 2'd1,
    LD_SZ_WORD = 2'd2,
    LD_SZ_RSVD = 2'd3
  } ld_size_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ld_state_t;

  function automatic int offs_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_ext_unit_if.sv
// Valid/ready load-path bus between the memory stage and the load aligner.
interface load_ext_unit_if #(
  parameter int DATA_W = 32
);
  localparam int OFFS_W = load_ext_pkg::offs_width(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFFS_W-1:0] in_offs;
  logic [1:0]        in_size;
  logic              in_sext;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;

  modport master (
    output in_valid, in_data, in_offs, in_size, in_sext, out_ready,
    input  in_ready, out_valid, out_data, out_misalign
  );

  modport slave (
    input  in_valid, in_data, in_offs, in_size, in_sext, out_ready,
    output in_ready, out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/sign_zero_ext.sv
// Combinational extender: widens an IN_W-bit lane to OUT_W bits with sign or zero fill.
module sign_zero_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  input  logic             sext,
  output logic [OUT_W-1:0] dout
);
  generate
    if (OUT_W > IN_W) begin : g_fill
      assign dout = {{(OUT_W - IN_W){sext & din[IN_W-1]}}, din};
    end else begin : g_pass
      assign dout = din[OUT_W-1:0];
    end
  endgenerate
endmodule

// File: rtl/load_ext_unit.sv
// Registered load aligner/extender with a 2-entry skid buffer on a valid/ready interface.
// Optional LOAD_MISALIGN_CHK_EN flags offsets that are illegal for the access size.
module load_ext_unit
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  load_ext_unit_if.slave bus
);
  localparam int OFFS_W = offs_width(DATA_W);

  ld_state_t         state_reg, state_next;
  logic              in_ready_reg, out_valid_reg;
  logic [DATA_W-1:0] out_data_reg, skid_data_reg;
  logic              load_out, load_skid, skid_to_out;
  logic              in_fire, out_fire;
  ld_size_t          size;
  logic [OFFS_W-1:0] eff_offs;
  logic [DATA_W-1:0] lane, proc_data;
  logic [DATA_W-1:0] ext_lane [3];

  assign size     = ld_size_t'(bus.in_size);
  assign in_fire  = bus.in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & bus.out_ready;

  // Halfword and word accesses are forced onto their natural alignment.
  always_comb begin
    eff_offs = '0;
    case (size)
      LD_SZ_BYTE: eff_offs = bus.in_offs;
      LD_SZ_HALF: eff_offs = {bus.in_offs[OFFS_W-1:1], 1'b0};
      default:    eff_offs = '0;
    endcase
  end

  assign lane = bus.in_data >> {eff_offs, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      sign_zero_ext #(.IN_W(8 << gi), .OUT_W(DATA_W)) u_ext (
        .din  (lane[(8 << gi) - 1:0]),
        .sext (bus.in_sext),
        .dout (ext_lane[gi])
      );
    end
  endgenerate

  always_comb begin
    proc_data = ext_lane[2];
    case (size)
      LD_SZ_BYTE: proc_data = ext_lane[0];
      LD_SZ_HALF: proc_data = ext_lane[1];
      default:    proc_data = ext_lane[2];
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_reg)
      ST_EMPTY: if (in_fire) begin
        state_next = ST_ONE;
        load_out   = 1'b1;
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_next = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          load_out = 1'b1;
        end
      end
      ST_TWO: if (out_fire) begin
        state_next  = ST_ONE;
        skid_to_out = 1'b1;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Handshake flags are registered from next-state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != ST_TWO);
      out_valid_reg <= (state_next != ST_EMPTY);
      if (load_out)    out_data_reg  <= proc_data;
      if (skid_to_out) out_data_reg  <= skid_data_reg;
      if (load_skid)   skid_data_reg <= proc_data;
    end
  end

`ifdef LOAD_MISALIGN_CHK_EN
  logic proc_mis, out_mis_reg, skid_mis_reg;

  always_comb begin
    proc_mis = 1'b0;
    case (size)
      LD_SZ_BYTE: proc_mis = 1'b0;
      LD_SZ_HALF: proc_mis = bus.in_offs[0];
      default:    proc_mis = (bus.in_offs != '0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mis_reg  <= 1'b0;
      skid_mis_reg <= 1'b0;
    end else begin
      if (load_out)    out_mis_reg  <= proc_mis;
      if (skid_to_out) out_mis_reg  <= skid_mis_reg;
      if (load_skid)   skid_mis_reg <= proc_mis;
    end
  end

  assign bus.out_misalign = out_mis_reg;
`else
  assign bus.out_misalign = 1'b0;
`endif

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_load_ext_unit.sv
// Directed self-checking bench for load_ext_unit (honours LOAD_MISALIGN_CHK_EN if defined).
module tb_load_ext_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_ext_unit_if #(.DATA_W(32)) bus ();

  load_ext_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef LOAD_MISALIGN_CHK_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] o,
                       input logic [1:0] s, input logic x);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_offs  = o;
    bus.in_size  = s;
    bus.in_sext  = x;
  endtask

  // Reference: pick the addressed bytes explicitly, then extend.
  function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [1:0] o,
                                           input logic [1:0] s, input logic x);
    logic [7:0]  b;
    logic [15:0] h;
    case (s)
      2'd0: begin
        case (o)
          2'd0: b = d[7:0];
          2'd1: b = d[15:8];
          2'd2: b = d[23:16];
          default: b = d[31:24];
        endcase
        return (x && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
      end
      2'd1: begin
        h = o[1] ? d[31:16] : d[15:0];
        return (x && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      end
      default: return d;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [1:0] o, input logic [1:0] s);
    if (s == 2'd0) return 1'b0;
    if (s == 2'd1) return MIS_ON & o[0];
    return MIS_ON & (o != 2'd0);
  endfunction

  logic [31:0] exp_d;
  logic        exp_m;
  logic [31:0] rd;
  logic [1:0]  ro, rs;
  logic        rx;

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_misalign", {31'b0, bus.out_misalign}, 32'd0);

    // 2: byte lanes
    drive(1'b1, 32'h1234_80F0, 2'd1, 2'd0, 1'b1);
    tick();
    check("byte_sext_valid", {31'b0, bus.out_valid}, 32'd1);
    check("byte_sext", bus.out_data, 32'hFFFF_FF80);
    drive(1'b1, 32'h1234_80F0, 2'd1, 2'd0, 1'b0);
    tick();
    check("byte_zext", bus.out_data, 32'h0000_0080);
    drive(1'b1, 32'h1234_80F0, 2'd3, 2'd0, 1'b1);
    tick();
    check("byte_offs3", bus.out_data, 32'h0000_0012);

    // 3: halfword and word alignment
    drive(1'b1, 32'h8001_7FFF, 2'd2, 2'd1, 1'b1);
    tick();
    check("half_offs2", bus.out_data, 32'hFFFF_8001);
    check("half_offs2_mis", {31'b0, bus.out_misalign}, 32'd0);
    drive(1'b1, 32'h8001_7FFF, 2'd3, 2'd1, 1'b1);
    tick();
    check("half_offs3", bus.out_data, 32'hFFFF_8001);
    check("half_offs3_mis", {31'b0, bus.out_misalign}, {31'b0, MIS_ON});
    drive(1'b1, 32'h8001_7FFF, 2'd0, 2'd1, 1'b1);
    tick();
    check("half_offs0_pos", bus.out_data, 32'h0000_7FFF);
    drive(1'b1, 32'h8001_7FFF, 2'd1, 2'd2, 1'b1);
    tick();
    check("word_offs1", bus.out_data, 32'h8001_7FFF);
    check("word_offs1_mis", {31'b0, bus.out_misalign}, {31'b0, MIS_ON});
    drive(1'b1, 32'hCAFE_0001, 2'd2, 2'd3, 1'b0);
    tick();
    check("rsvd_as_word", bus.out_data, 32'hCAFE_0001);
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    tick();
    check("idle_valid", {31'b0, bus.out_valid}, 32'd0);

    // 4: backpressure through the skid buffer
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 2'd0, 2'd2, 1'b0);
    tick();
    check("bp_a_out", bus.out_data, 32'hAAAA_0001);
    check("bp_one_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'hBBBB_0002, 2'd0, 2'd2, 1'b0);
    tick();
    check("bp_two_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp_hold_a", bus.out_data, 32'hAAAA_0001);
    drive(1'b1, 32'hCCCC_0003, 2'd0, 2'd2, 1'b0);
    tick();
    check("bp_c_blocked", {31'b0, bus.in_ready}, 32'd0);
    check("bp_still_a", bus.out_data, 32'hAAAA_0001);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_out", bus.out_data, 32'hBBBB_0002);
    check("bp_b_valid", {31'b0, bus.out_valid}, 32'd1);
    tick();
    check("bp_c_out", bus.out_data, 32'hCCCC_0003);
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    tick();
    check("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // 5: streaming at full rate
    for (int i = 0; i < 16; i++) begin
      rd = $urandom;
      ro = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      rx = 1'($urandom_range(0, 1));
      exp_d = ref_data(rd, ro, rs, rx);
      exp_m = ref_mis(ro, rs);
      drive(1'b1, rd, ro, rs, rx);
      tick();
      check($sformatf("stream%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      check($sformatf("stream%0d_data", i), bus.out_data, exp_d);
      check($sformatf("stream%0d_mis", i), {31'b0, bus.out_misalign}, {31'b0, exp_m});
      $display("stream beat %0d: data=%h offs=%0d size=%0d sext=%0d -> %h", i, rd, ro, rs, rx, bus.out_data);
    end
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    tick();

    // 6: reset while in TWO
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDDDD_0004, 2'd0, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'hEEEE_0005, 2'd0, 2'd2, 1'b0);
    tick();
    check("rst2_two_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_0006, 2'd0, 2'd2, 1'b0);
    tick();
    check("rst2_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst2_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst2_data", bus.out_data, 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst2_no_stale%0d", i), {31'b0, bus.out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
